// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the serial current-DAC writer.
// Frame layout on the wire, MSB first: command, channel address, 16-bit code.
package dac_pkg;

  localparam int          FRAME_BITS       = 24;
  localparam logic [3:0]  CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [15:0] CUR_ZERO         = 16'h8000;

  typedef logic [2:0] dac_state_t;

  localparam dac_state_t ST_IDLE  = 3'd0;
  localparam dac_state_t ST_SETUP = 3'd1;
  localparam dac_state_t ST_SHIFT = 3'd2;
  localparam dac_state_t ST_HOLD  = 3'd3;
  localparam dac_state_t ST_GAP   = 3'd4;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  addr,
                                                        input logic [15:0] code);
    return {CMD_WRITE_UPDATE, addr, code};
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous ready level.
// A level already high when reset is released must fall and rise again before it counts.
module sync_rise_det (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;
  logic fill0;
  logic fill1;
  logic armed;

  // fill1 marks that sync holds a real sample rather than its reset value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      fill0 <= 1'b0;
      fill1 <= 1'b0;
      armed <= 1'b0;
    end else begin
      meta  <= async_in;
      sync  <= meta;
      prev  <= sync;
      fill0 <= 1'b1;
      fill1 <= fill0;
      if (fill1 && !sync) armed <= 1'b1;
    end
  end

  assign rise = sync & ~prev & armed;

endmodule

// File: rtl/ctrl_dac_writer.sv
// Ships each new controller current code to a serial DAC as one 24-bit frame,
// keeping only the newest code if several arrive while a frame is in flight.
//
//   state | meaning
//   IDLE  | cs_n high, waiting for a pending code with enable set
//   SETUP | cs_n low, sclk low, first bit on mosi
//   SHIFT | 24 sclk periods, low half then high half
//   HOLD  | sclk low, cs_n still low before release
//   GAP   | cs_n high, minimum spacing before the next frame
module ctrl_dac_writer
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter int         GAP_CYC  = 2,
  parameter logic [3:0] DAC_ADDR = 4'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dac_enable,
  input  logic        ctrl_ready,
  input  logic [15:0] ctrl_data,
  output logic        dac_busy,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic [15:0] last_code,
  output logic [15:0] overrun_cnt
);

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYC - 1);
  localparam logic [4:0] BIT_LD = 5'(FRAME_BITS - 1);

  dac_state_t              state;
  logic [7:0]              div_cnt;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-2:0]   shreg;
  logic [15:0]             cur_code;
  logic                    pending;
  logic [15:0]             pend_code;
  logic                    trig_raw;
  logic                    trig;
  logic                    cnt_done;
  logic                    ld;
  logic [15:0]             ld_code;
  logic [FRAME_BITS-1:0]   frame_ld;

  sync_rise_det u_rdy_det (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (ctrl_ready),
    .rise     (trig_raw)
  );

  assign trig     = trig_raw & dac_enable;
  assign cnt_done = (div_cnt == 8'd0);
  // A trigger arriving in the launch cycle is sent directly, so a code landing
  // in the last GAP cycle starts the very next frame without an extra IDLE cycle.
  assign ld       = dac_enable & (pending | trig) &
                    ((state == ST_IDLE) | ((state == ST_GAP) & cnt_done));
  assign ld_code  = trig ? ctrl_data : pend_code;
  assign frame_ld = build_frame(DAC_ADDR, ld_code);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending     <= 1'b0;
      pend_code   <= CUR_ZERO;
      overrun_cnt <= 16'h0000;
    end else if (!dac_enable) begin
      pending <= 1'b0;
    end else if (trig) begin
      if (pending && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
      if (ld) begin
        pending <= 1'b0;
      end else begin
        pending   <= 1'b1;
        pend_code <= ctrl_data;
      end
    end else if (ld) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 5'd0;
      shreg     <= '0;
      cur_code  <= CUR_ZERO;
      dac_cs_n  <= 1'b1;
      dac_sclk  <= 1'b0;
      dac_mosi  <= 1'b0;
      dac_busy  <= 1'b0;
      last_code <= CUR_ZERO;
    end else if (ld) begin
      state    <= ST_SETUP;
      div_cnt  <= DIV_LD;
      bit_cnt  <= BIT_LD;
      shreg    <= frame_ld[FRAME_BITS-2:0];
      cur_code <= ld_code;
      dac_cs_n <= 1'b0;
      dac_sclk <= 1'b0;
      dac_mosi <= frame_ld[FRAME_BITS-1];
      dac_busy <= 1'b1;
    end else begin
      case (state)
        ST_SETUP: begin
          if (cnt_done) begin
            state   <= ST_SHIFT;
            div_cnt <= DIV_LD;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_SHIFT: begin
          if (!cnt_done) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LD;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else begin
              // mosi only moves together with sclk falling
              dac_sclk <= 1'b0;
              if (bit_cnt == 5'd0) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt  <= bit_cnt - 5'd1;
                dac_mosi <= shreg[FRAME_BITS-2];
                shreg    <= {shreg[FRAME_BITS-3:0], 1'b0};
              end
            end
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            state     <= ST_GAP;
            div_cnt   <= GAP_LD;
            dac_cs_n  <= 1'b1;
            last_code <= cur_code;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt_done) begin
            state    <= ST_IDLE;
            dac_busy <= 1'b0;
            dac_mosi <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_dac_writer.sv
// Bench for ctrl_dac_writer: default instance plus a fast CLK_DIV=1/GAP_CYC=1 instance,
// with a pin-level frame decoder checked against expected code queues.
module tb_ctrl_dac_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        en   [2];
  logic        rdy  [2];
  logic [15:0] data [2];
  logic        busy [2];
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  logic [15:0] last [2];
  logic [15:0] ovr  [2];

  ctrl_dac_writer #(.CLK_DIV(2), .GAP_CYC(2), .DAC_ADDR(4'h0)) u_dut_a (
    .clk(clk), .rstn(rstn[0]), .dac_enable(en[0]), .ctrl_ready(rdy[0]), .ctrl_data(data[0]),
    .dac_busy(busy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]),
    .last_code(last[0]), .overrun_cnt(ovr[0]));

  ctrl_dac_writer #(.CLK_DIV(1), .GAP_CYC(1), .DAC_ADDR(4'h5)) u_dut_b (
    .clk(clk), .rstn(rstn[1]), .dac_enable(en[1]), .ctrl_ready(rdy[1]), .ctrl_data(data[1]),
    .dac_busy(busy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]),
    .last_code(last[1]), .overrun_cnt(ovr[1]));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          nfall [2];
  int          last_busy_len [2];
  logic [23:0] last_frame [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [3:0] addr_of(input int i);
    return (i == 0) ? 4'h0 : 4'h5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decodes frames from the pins and checks them against the expected code queues.
  task automatic monitor();
    logic        pcs [2];
    logic        psclk [2];
    logic        pmosi [2];
    logic        pbusy [2];
    logic        infr [2];
    logic        glitch [2];
    int          cs_len [2];
    int          nrise [2];
    int          blen [2];
    int          nfr [2];
    logic [23:0] bits [2];
    logic [15:0] e;
    int          qs;
    for (int i = 0; i < 2; i++) begin
      pcs[i] = 1'b1; psclk[i] = 1'b0; pmosi[i] = 1'b0; pbusy[i] = 1'b0;
      infr[i] = 1'b0; glitch[i] = 1'b0; cs_len[i] = 0; nrise[i] = 0;
      blen[i] = 0; nfr[i] = 0; bits[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rstn[i]) begin
          infr[i] = 1'b0; blen[i] = 0; nfr[i] = 0;
          pcs[i] = 1'b1; psclk[i] = 1'b0; pmosi[i] = 1'b0; pbusy[i] = 1'b0;
        end else begin
          qs = (i == 0) ? exp_q0.size() : exp_q1.size();
          if (pcs[i] && !cs_n[i]) begin
            nfall[i]++;
            chk("frame_expected", 32'(qs > 0), 32'd1);
            infr[i] = 1'b1; cs_len[i] = 0; nrise[i] = 0; bits[i] = '0; glitch[i] = 1'b0;
            nfr[i]++;
          end
          if (!cs_n[i]) begin
            cs_len[i]++;
            chk("busy_in_frame", 32'(busy[i]), 32'd1);
            if (!psclk[i] && sclk[i]) begin
              bits[i] = {bits[i][22:0], mosi[i]};
              nrise[i]++;
            end
            if (sclk[i] && (mosi[i] !== pmosi[i])) glitch[i] = 1'b1;
          end else begin
            chk("sclk_idle_low", 32'(sclk[i]), 32'd0);
          end
          if (!pcs[i] && cs_n[i] && infr[i]) begin
            infr[i] = 1'b0;
            e = 16'h0000;
            if (i == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (i == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            last_frame[i] = bits[i];
            chk("sclk_rises", nrise[i], 32'd24);
            chk("frame_bits", 32'(bits[i]), 32'({4'b0011, addr_of(i), e}));
            chk("cs_low_len", cs_len[i], 50 * div_of(i));
            chk("mosi_stable", 32'(glitch[i]), 32'd0);
            chk("last_code_update", 32'(last[i]), 32'(e));
          end
          if (busy[i]) begin
            blen[i]++;
          end else if (pbusy[i]) begin
            chk("busy_len", blen[i], nfr[i] * (50 * div_of(i) + gap_of(i)));
            last_busy_len[i] = blen[i];
            blen[i] = 0;
            nfr[i]  = 0;
          end
          pcs[i] = cs_n[i]; psclk[i] = sclk[i]; pmosi[i] = mosi[i]; pbusy[i] = busy[i];
        end
      end
    end
  endtask

  task automatic wait_idle(input int i, input int max);
    int k;
    k = 0;
    while (busy[i] && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 32'(busy[i]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cs_low(input int i, input string name);
    int k;
    k = 0;
    while (cs_n[i] && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(cs_n[i]), 32'd0);
  endtask

  task automatic pulse(input int i, input logic [15:0] d);
    data[i] = d;
    rdy[i]  = 1'b1;
    repeat (5) @(negedge clk);
    rdy[i]  = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send(input int i, input logic [15:0] d);
    int f;
    int k;
    f = nfall[i];
    if (i == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
    data[i] = d;
    rdy[i]  = 1'b1;
    repeat (4) @(negedge clk);
    rdy[i]  = 1'b0;
    k = 0;
    while (nfall[i] <= f && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("frame_started", 32'(nfall[i] > f), 32'd1);
    wait_idle(i, 400);
  endtask

  initial begin
    int lat;
    int idx;
    int f0;
    logic seen_high;
    logic [15:0] c;
    logic [15:0] codes [6];

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; en[i] = 1'b1; rdy[i] = 1'b0; data[i] = 16'h0000;
      nfall[i] = 0; last_busy_len[i] = 0; last_frame[i] = '0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", 32'(cs_n[i]), 32'd1);
      chk("rst_sclk", 32'(sclk[i]), 32'd0);
      chk("rst_mosi", 32'(mosi[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_last_code", 32'(last[i]), 32'h8000);
      chk("rst_overrun", 32'(ovr[i]), 32'd0);
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    repeat (5) @(negedge clk);

    // single code
    exp_q0.push_back(16'h9000);
    data[0] = 16'h9000;
    rdy[0]  = 1'b1;
    lat = 0;
    while (cs_n[0] && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("cs_latency_ok", 32'(!cs_n[0] && lat <= 4), 32'd1);
    repeat (4) @(negedge clk);
    rdy[0] = 1'b0;
    wait_idle(0, 400);
    chk("single_frame_word", 32'(last_frame[0]), 32'h309000);
    chk("single_busy_len", last_busy_len[0], 32'd102);
    chk("single_last_code", 32'(last[0]), 32'h9000);
    chk("single_overrun", 32'(ovr[0]), 32'd0);

    // back-to-back, middle code overwritten
    exp_q0.push_back(16'h7000);
    exp_q0.push_back(16'h7200);
    pulse(0, 16'h7000);
    pulse(0, 16'h7100);
    pulse(0, 16'h7200);
    wait_idle(0, 600);
    chk("b2b_overrun", 32'(ovr[0]), 32'd1);
    chk("b2b_last_code", 32'(last[0]), 32'h7200);
    chk("b2b_busy_len", last_busy_len[0], 32'd204);

    // trigger landing in the last GAP cycle
    exp_q0.push_back(16'h1234);
    exp_q0.push_back(16'h4321);
    data[0] = 16'h1234;
    rdy[0]  = 1'b1;
    wait_cs_low(0, "boundary_first_start");
    for (int j = 1; j <= 99; j++) begin
      @(negedge clk);
      if (j == 5) rdy[0] = 1'b0;
    end
    data[0] = 16'h4321;
    rdy[0]  = 1'b1;
    seen_high = 1'b0;
    idx = 99;
    while (idx < 110) begin
      @(negedge clk);
      idx++;
      if (cs_n[0]) seen_high = 1'b1;
      else if (seen_high) break;
    end
    chk("boundary_restart_cycle", idx, 32'd102);
    repeat (3) @(negedge clk);
    rdy[0] = 1'b0;
    wait_idle(0, 400);
    chk("boundary_overrun", 32'(ovr[0]), 32'd1);
    chk("boundary_last_code", 32'(last[0]), 32'h4321);
    chk("boundary_busy_len", last_busy_len[0], 32'd204);

    // enable dropped at bit 10 with a code pending
    f0 = nfall[0];
    exp_q0.push_back(16'h0F0F);
    data[0] = 16'h0F0F;
    rdy[0]  = 1'b1;
    wait_cs_low(0, "endrop_start");
    for (int j = 1; j <= 43; j++) begin
      @(negedge clk);
      if (j == 5)  rdy[0] = 1'b0;
      if (j == 10) begin data[0] = 16'hAAAA; rdy[0] = 1'b1; end
      if (j == 15) rdy[0] = 1'b0;
      if (j == 43) en[0] = 1'b0;
    end
    wait_idle(0, 400);
    repeat (10) @(negedge clk);
    data[0] = 16'h5555;
    rdy[0]  = 1'b1;
    repeat (5) @(negedge clk);
    rdy[0]  = 1'b0;
    repeat (10) @(negedge clk);
    en[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("endrop_frame_count", nfall[0] - f0, 32'd1);
    chk("endrop_overrun", 32'(ovr[0]), 32'd1);
    chk("endrop_last_code", 32'(last[0]), 32'h0F0F);

    // reset in the middle of bit 12, ready held high through reset
    exp_q0.push_back(16'hC3C3);
    data[0] = 16'hC3C3;
    rdy[0]  = 1'b1;
    wait_cs_low(0, "rstmid_start");
    repeat (52) @(negedge clk);
    chk("rstmid_sclk_high_before", 32'(sclk[0]), 32'd1);
    #2 rstn[0] = 1'b0;
    #1;
    chk("rstmid_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rstmid_sclk", 32'(sclk[0]), 32'd0);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    f0 = nfall[0];
    repeat (30) @(negedge clk);
    chk("rstmid_no_stale_trigger", nfall[0] - f0, 32'd0);
    chk("rstmid_last_code", 32'(last[0]), 32'h8000);
    chk("rstmid_overrun", 32'(ovr[0]), 32'd0);
    rdy[0] = 1'b0;
    repeat (5) @(negedge clk);
    send(0, 16'h8001);
    chk("rstmid_new_rise_frames", nfall[0] - f0, 32'd1);
    chk("rstmid_new_last_code", 32'(last[0]), 32'h8001);

    // fast instance, extreme and random codes
    codes[0] = 16'h0000;
    codes[1] = 16'hFFFF;
    for (int n = 2; n < 6; n++) codes[n] = 16'($urandom_range(0, 65535));
    for (int n = 0; n < 6; n++) begin
      c = codes[n];
      send(1, c);
      chk("fast_last_code", 32'(last[1]), 32'(c));
      chk("fast_frame_word", 32'(last_frame[1]), 32'({4'b0011, 4'h5, c}));
      chk("fast_busy_len", last_busy_len[1], 32'd51);
    end
    chk("fast_overrun", 32'(ovr[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
